// File: rtl/mul8_recon.sv
// mul8_recon: sequential 8-bit unsigned shift-add multiplier that rebuilds a
// dividend from divider outputs, P = SC * Q + R. One iteration per clock and
// eight iterations per run, so the latency is fixed regardless of operands.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only while busy = 0
//   SC     - divisor / multiplicand (8 bits), sampled with start
//   Q      - quotient / multiplier (8 bits), sampled with start
//   R      - remainder / addend (8 bits), sampled with start
//   busy   - high while a run is in progress
//   done   - one-cycle pulse when P is updated
//   P      - reconstructed dividend (16 bits), held until the next done
//   err    - consistency flag, qualified by done
//
// Build option: define MUL8_RECON_CHECK_EN to register err with P. err is set
// when the triple cannot come from a valid 8-bit division (SC == 0, R >= SC,
// or a dividend wider than 8 bits). Without the macro err is tied to 0.
module mul8_recon (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  SC,
  input  logic [7:0]  Q,
  input  logic [7:0]  R,
  output logic        busy,
  output logic        done,
  output logic [15:0] P,
  output logic        err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_p;

  logic [15:0] w_addend;
  logic [15:0] w_sum;

  // The largest possible result is 255*255+255 = 65280, so the 16-bit add
  // never needs a carry out.
  assign w_addend = r_mplier[0] ? r_mcand : 16'h0000;
  assign w_sum    = r_acc + w_addend;

  // NOTE: all state is assigned with <= so every register samples the values
  // from before the edge; w_sum is therefore the sum for the current iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc    <= 16'h0000;
      r_mcand  <= 16'h0000;
      r_mplier <= 8'h00;
      r_cnt    <= 3'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_p      <= 16'h0000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {8'h00, SC};
            r_mplier <= Q;
            r_acc    <= {8'h00, R};
            r_cnt    <= 3'd0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_p     <= w_sum;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign P    = r_p;

`ifdef MUL8_RECON_CHECK_EN
  // Shadow copies of SC and R: the inputs may change after the accept edge.
  logic [7:0] r_sc_sh;
  logic [7:0] r_r_sh;
  logic       r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc_sh <= 8'h00;
      r_r_sh  <= 8'h00;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_sc_sh <= SC;
        r_r_sh  <= R;
      end
      if (r_state == RUN && r_cnt == 3'd7) begin
        r_err <= (r_sc_sh == 8'h00) | (r_r_sh >= r_sc_sh) | (w_sum[15:8] != 8'h00);
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
